// File: rtl/mem_read_accelerator_control_pkg.sv
// Shared definitions for the mem_read_accelerator AXI4-Lite control slave:
// register offsets, control/status bit positions, FSM state types and a strobe helper.
package mem_read_accelerator_control_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] ADDR_AP_CTRL     = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_GIE         = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_IER         = 6'h08;
    localparam logic [ADDR_W-1:0] ADDR_ISR         = 6'h0C;
    localparam logic [ADDR_W-1:0] ADDR_ADDR_INCR   = 6'h10;
    localparam logic [ADDR_W-1:0] ADDR_MEM_MAX     = 6'h18;
    localparam logic [ADDR_W-1:0] ADDR_DATA_IN_LO  = 6'h20;
    localparam logic [ADDR_W-1:0] ADDR_DATA_IN_HI  = 6'h24;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_DONE  = 1;
    localparam int unsigned CTRL_IDLE  = 2;
    localparam int unsigned CTRL_READY = 3;
    localparam int unsigned CTRL_AUTO  = 7;

    localparam int unsigned ISR_DONE  = 0;
    localparam int unsigned ISR_READY = 1;

    typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
    typedef enum logic       {RDIDLE, RDDATA}         rd_state_t;

    // Expand per-byte write strobes into a full-width bit mask.
    function automatic logic [DATA_W-1:0] wstrb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_read_accelerator_control_s_axi.sv
// AXI4-Lite control register file for the mem_read_accelerator kernel: scalar
// arguments, ap_ctrl_hs handshake bits and a level interrupt.
module mem_read_accelerator_control_s_axi
    import mem_read_accelerator_control_pkg::*;
#(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                              ap_clk,
    input  logic                              areset,
    input  logic                              s_axi_control_awvalid,
    output logic                              s_axi_control_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_control_awaddr,
    input  logic                              s_axi_control_wvalid,
    output logic                              s_axi_control_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_control_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_control_wstrb,
    output logic                              s_axi_control_bvalid,
    input  logic                              s_axi_control_bready,
    output logic [1:0]                        s_axi_control_bresp,
    input  logic                              s_axi_control_arvalid,
    output logic                              s_axi_control_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_control_araddr,
    output logic                              s_axi_control_rvalid,
    input  logic                              s_axi_control_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_control_rdata,
    output logic [1:0]                        s_axi_control_rresp,
    output logic                              ap_start,
    input  logic                              ap_done,
    input  logic                              ap_idle,
    input  logic                              ap_ready,
    output logic [31:0]                       addr_incr,
    output logic [31:0]                       mem_max_addr,
    output logic [63:0]                       data_in,
    output logic                              interrupt
);

    wr_state_t                          r_wstate, w_wnext;
    rd_state_t                          r_rstate, w_rnext;
    logic                               r_awready, r_wready, r_bvalid;
    logic                               r_arready, r_rvalid;
    logic [C_S_AXI_ADDR_WIDTH-1:0]      r_waddr;
    logic [C_S_AXI_DATA_WIDTH-1:0]      r_rdata, w_rdata_mux;

    logic                               r_ap_start, r_auto_restart, r_done_st, r_ready_st;
    logic                               r_gie, r_interrupt;
    logic [1:0]                         r_ier, r_isr;
    logic [31:0]                        r_addr_incr, r_mem_max, r_data_lo, r_data_hi;

    logic                               w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                               w_ctrl_we, w_ctrl_rd;
    logic [C_S_AXI_DATA_WIDTH-1:0]      w_mask;

    assign w_aw_hs   = s_axi_control_awvalid & r_awready;
    assign w_w_hs    = s_axi_control_wvalid  & r_wready;
    assign w_b_hs    = s_axi_control_bready  & r_bvalid;
    assign w_ar_hs   = s_axi_control_arvalid & r_arready;
    assign w_r_hs    = s_axi_control_rready  & r_rvalid;
    assign w_mask    = wstrb_mask(s_axi_control_wstrb);
    assign w_ctrl_we = w_w_hs && (r_waddr == ADDR_AP_CTRL) && s_axi_control_wstrb[0];
    assign w_ctrl_rd = w_ar_hs && (s_axi_control_araddr == ADDR_AP_CTRL);

    // Write channel next state.
    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            WRIDLE:  if (w_aw_hs) w_wnext = WRDATA;
            WRDATA:  if (w_w_hs)  w_wnext = WRRESP;
            WRRESP:  if (w_b_hs)  w_wnext = WRIDLE;
            default: w_wnext = WRIDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they read 0 during reset.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_wstate  <= WRIDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_waddr   <= '0;
        end else begin
            r_wstate  <= w_wnext;
            r_awready <= (w_wnext == WRIDLE);
            r_wready  <= (w_wnext == WRDATA);
            r_bvalid  <= (w_wnext == WRRESP);
            if (w_aw_hs) r_waddr <= s_axi_control_awaddr;
        end
    end

    // Read channel next state.
    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            RDIDLE:  if (w_ar_hs) w_rnext = RDDATA;
            RDDATA:  if (w_r_hs)  w_rnext = RDIDLE;
            default: w_rnext = RDIDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_rstate  <= RDIDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rstate  <= w_rnext;
            r_arready <= (w_rnext == RDIDLE);
            r_rvalid  <= (w_rnext == RDDATA);
            if (w_ar_hs) r_rdata <= w_rdata_mux;
        end
    end

    // Read data mux; unmapped offsets return zero.
    always_comb begin
        w_rdata_mux = '0;
        case (s_axi_control_araddr)
            ADDR_AP_CTRL: begin
                w_rdata_mux[CTRL_START] = r_ap_start;
                w_rdata_mux[CTRL_DONE]  = r_done_st;
                w_rdata_mux[CTRL_IDLE]  = ap_idle;
                w_rdata_mux[CTRL_READY] = r_ready_st;
                w_rdata_mux[CTRL_AUTO]  = r_auto_restart;
            end
            ADDR_GIE:        w_rdata_mux[0]   = r_gie;
            ADDR_IER:        w_rdata_mux[1:0] = r_ier;
            ADDR_ISR:        w_rdata_mux[1:0] = r_isr;
            ADDR_ADDR_INCR:  w_rdata_mux      = r_addr_incr;
            ADDR_MEM_MAX:    w_rdata_mux      = r_mem_max;
            ADDR_DATA_IN_LO: w_rdata_mux      = r_data_lo;
            ADDR_DATA_IN_HI: w_rdata_mux      = r_data_hi;
            default:         w_rdata_mux      = '0;
        endcase
    end

    // Control, interrupt and scalar registers; hardware set beats host clear/toggle.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_ap_start     <= 1'b0;
            r_auto_restart <= 1'b0;
            r_done_st      <= 1'b0;
            r_ready_st     <= 1'b0;
            r_gie          <= 1'b0;
            r_ier          <= '0;
            r_isr          <= '0;
            r_interrupt    <= 1'b0;
            r_addr_incr    <= '0;
            r_mem_max      <= '0;
            r_data_lo      <= '0;
            r_data_hi      <= '0;
        end else begin
            if (w_ctrl_we && s_axi_control_wdata[CTRL_START]) r_ap_start <= 1'b1;
            else if (ap_ready && !r_auto_restart)              r_ap_start <= 1'b0;

            if (w_ctrl_we) r_auto_restart <= s_axi_control_wdata[CTRL_AUTO];

            if (ap_done)        r_done_st <= 1'b1;
            else if (w_ctrl_rd) r_done_st <= 1'b0;

            if (ap_ready)       r_ready_st <= 1'b1;
            else if (w_ctrl_rd) r_ready_st <= 1'b0;

            if (w_w_hs && (r_waddr == ADDR_GIE) && s_axi_control_wstrb[0])
                r_gie <= s_axi_control_wdata[0];
            if (w_w_hs && (r_waddr == ADDR_IER) && s_axi_control_wstrb[0])
                r_ier <= s_axi_control_wdata[1:0];

            if (ap_done && r_ier[ISR_DONE])
                r_isr[ISR_DONE] <= 1'b1;
            else if (w_w_hs && (r_waddr == ADDR_ISR) && s_axi_control_wstrb[0] && s_axi_control_wdata[ISR_DONE])
                r_isr[ISR_DONE] <= ~r_isr[ISR_DONE];

            if (ap_ready && r_ier[ISR_READY])
                r_isr[ISR_READY] <= 1'b1;
            else if (w_w_hs && (r_waddr == ADDR_ISR) && s_axi_control_wstrb[0] && s_axi_control_wdata[ISR_READY])
                r_isr[ISR_READY] <= ~r_isr[ISR_READY];

            r_interrupt <= r_gie & (|r_isr);

            if (w_w_hs && (r_waddr == ADDR_ADDR_INCR))
                r_addr_incr <= (r_addr_incr & ~w_mask) | (s_axi_control_wdata & w_mask);
            if (w_w_hs && (r_waddr == ADDR_MEM_MAX))
                r_mem_max <= (r_mem_max & ~w_mask) | (s_axi_control_wdata & w_mask);
            if (w_w_hs && (r_waddr == ADDR_DATA_IN_LO))
                r_data_lo <= (r_data_lo & ~w_mask) | (s_axi_control_wdata & w_mask);
            if (w_w_hs && (r_waddr == ADDR_DATA_IN_HI))
                r_data_hi <= (r_data_hi & ~w_mask) | (s_axi_control_wdata & w_mask);
        end
    end

    assign s_axi_control_awready = r_awready;
    assign s_axi_control_wready  = r_wready;
    assign s_axi_control_bvalid  = r_bvalid;
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_arready = r_arready;
    assign s_axi_control_rvalid  = r_rvalid;
    assign s_axi_control_rdata   = r_rdata;
    assign s_axi_control_rresp   = 2'b00;
    assign ap_start              = r_ap_start;
    assign addr_incr             = r_addr_incr;
    assign mem_max_addr          = r_mem_max;
    assign data_in               = {r_data_hi, r_data_lo};
    assign interrupt             = r_interrupt;

endmodule
